// File: rtl/vend_ctrl.sv
// Vending-machine transaction controller: coin accumulation, product selection,
// confirm/cancel, dispense and change/refund sequencing with registered outputs.
module vend_ctrl #(
    parameter logic [7:0]  COIN0_VAL   = 8'd1,
    parameter logic [7:0]  COIN1_VAL   = 8'd5,
    parameter logic [7:0]  COIN2_VAL   = 8'd10,
    parameter logic [63:0] PRICE_TABLE = 64'h14_0F_0C_0A_08_05_03_00,
    parameter logic [7:0]  CREDIT_MAX  = 8'd99,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] coin,
    input  logic [2:0] goods,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       done,
    output logic [7:0] credit,
    output logic [7:0] price,
    output logic [7:0] change,
    output logic       change_valid,
    output logic       dispense,
    output logic       refund,
    output logic       err,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  credit_r, credit_s;
    logic [7:0]  price_r, price_s;
    logic [7:0]  change_r, change_s;
    logic        change_valid_r, change_valid_s;
    logic        dispense_r, dispense_s;
    logic        refund_r, refund_s;
    logic        err_r, err_s;
    logic        busy_r, busy_s;
    logic [31:0] timer_r, timer_s;
    logic        coin_hit_s;
    logic        go_refund_s;
    logic [8:0]  coin_sum_s;
    logic [7:0]  sel_price_s;

    function automatic logic [8:0] coin_value(input logic [2:0] c);
        return (c[0] ? {1'b0, COIN0_VAL} : 9'd0)
             + (c[1] ? {1'b0, COIN1_VAL} : 9'd0)
             + (c[2] ? {1'b0, COIN2_VAL} : 9'd0);
    endfunction

    function automatic logic [7:0] price_lookup(input logic [2:0] g);
        return PRICE_TABLE[{g, 3'b000} +: 8];
    endfunction

    // Credit never exceeds CREDIT_MAX; the sum is widened so the compare sees the carry.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [8:0] add);
        logic [8:0] total;
        total = {1'b0, base} + add;
        return (total > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : total[7:0];
    endfunction

    assign coin_hit_s  = |coin;
    assign coin_sum_s  = coin_value(coin);
    assign sel_price_s = price_lookup(goods);

    // Next-state and next-output decode; cancel outranks confirm, which outranks coin.
    always_comb begin
        state_s        = state_r;
        credit_s       = credit_r;
        price_s        = price_r;
        change_s       = change_r;
        change_valid_s = 1'b0;
        dispense_s     = 1'b0;
        refund_s       = 1'b0;
        err_s          = 1'b0;
        timer_s        = 32'd0;
        go_refund_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (confirm) begin
                    err_s = 1'b1;
                end else if (coin_hit_s) begin
                    credit_s = sat_add(8'd0, coin_sum_s);
                    state_s  = ST_COLLECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    go_refund_s = 1'b1;
                    err_s       = coin_hit_s;
                end else if (confirm) begin
                    if ((sel_price_s != 8'd0) && (credit_r >= sel_price_s)) begin
                        state_s    = ST_VEND;
                        price_s    = sel_price_s;
                        change_s   = credit_r - sel_price_s;
                        dispense_s = 1'b1;
                        err_s      = coin_hit_s;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (coin_hit_s) begin
                    credit_s = sat_add(credit_r, coin_sum_s);
                end else if (timer_r >= (TIMEOUT_CYC - 32'd1)) begin
                    go_refund_s = 1'b1;
                end else begin
                    timer_s = timer_r + 32'd1;
                end
            end
            ST_VEND: begin
                err_s = coin_hit_s;
                if (done) begin
                    change_valid_s = 1'b1;
                    credit_s       = 8'd0;
                    state_s        = ST_IDLE;
                end else begin
                    dispense_s = 1'b1;
                end
            end
            ST_REFUND: begin
                err_s   = coin_hit_s;
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                credit_s = 8'd0;
            end
        endcase
        if (go_refund_s) begin
            state_s        = ST_REFUND;
            change_s       = credit_r;
            change_valid_s = 1'b1;
            refund_s       = 1'b1;
            credit_s       = 8'd0;
        end else begin
            state_s = state_s;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            credit_r       <= 8'd0;
            price_r        <= 8'd0;
            change_r       <= 8'd0;
            change_valid_r <= 1'b0;
            dispense_r     <= 1'b0;
            refund_r       <= 1'b0;
            err_r          <= 1'b0;
            busy_r         <= 1'b0;
            timer_r        <= 32'd0;
        end else begin
            state_r        <= state_s;
            credit_r       <= credit_s;
            price_r        <= price_s;
            change_r       <= change_s;
            change_valid_r <= change_valid_s;
            dispense_r     <= dispense_s;
            refund_r       <= refund_s;
            err_r          <= err_s;
            busy_r         <= busy_s;
            timer_r        <= timer_s;
        end
    end

    assign credit       = credit_r;
    assign price        = price_r;
    assign change       = change_r;
    assign change_valid = change_valid_r;
    assign dispense     = dispense_r;
    assign refund       = refund_r;
    assign err          = err_r;
    assign busy         = busy_r;
    assign state        = state_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the transaction rules.
module tb_vend_ctrl;

    localparam int TMO = 16;
    localparam int CMAX = 99;
    localparam int PRICES [8] = '{0, 3, 5, 8, 10, 12, 15, 20};

    logic       clk;
    logic       rst_n;
    logic [2:0] coin;
    logic [2:0] goods;
    logic       confirm;
    logic       cancel;
    logic       done;
    logic [7:0] credit;
    logic [7:0] price;
    logic [7:0] change;
    logic       change_valid;
    logic       dispense;
    logic       refund;
    logic       err;
    logic       busy;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_state, m_credit, m_price, m_change, m_cyc, m_last;
    bit m_cv, m_refund, m_err;

    vend_ctrl #(.TIMEOUT_CYC(32'd16)) dut (
        .clk(clk), .rst_n(rst_n), .coin(coin), .goods(goods),
        .confirm(confirm), .cancel(cancel), .done(done),
        .credit(credit), .price(price), .change(change),
        .change_valid(change_valid), .dispense(dispense), .refund(refund),
        .err(err), .busy(busy), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [2:0] c, input logic [2:0] g, input logic cf,
                       input logic cn, input logic dn, input logic rs);
        coin = c; goods = g; confirm = cf; cancel = cn; done = dn; rst_n = rs;
        @(posedge clk);
        #1;
        coin = 3'd0; confirm = 1'b0; cancel = 1'b0; done = 1'b0;
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_refund();
        m_change = m_credit; m_cv = 1'b1; m_refund = 1'b1; m_credit = 0; m_state = 3;
    endtask

    task automatic model_step(input logic [2:0] c, input logic [2:0] g, input logic cf,
                              input logic cn, input logic dn, input logic rs);
        int sum;
        int p;
        sum = (c[0] ? 1 : 0) + (c[1] ? 5 : 0) + (c[2] ? 10 : 0);
        p = PRICES[g];
        m_cyc++;
        m_cv = 1'b0; m_refund = 1'b0; m_err = 1'b0;
        if (!rs) begin
            m_state = 0; m_credit = 0; m_price = 0; m_change = 0;
        end else if (m_state == 0) begin
            if (cf) m_err = 1'b1;
            else if (sum > 0) begin
                m_credit = min_i(sum, CMAX); m_state = 1; m_last = m_cyc;
            end
        end else if (m_state == 1) begin
            if (cn) begin
                model_refund(); m_err = (c != 3'd0);
            end else if (cf) begin
                m_last = m_cyc;
                if (p != 0 && m_credit >= p) begin
                    m_price = p; m_change = m_credit - p; m_state = 2; m_err = (c != 3'd0);
                end else m_err = 1'b1;
            end else if (sum > 0) begin
                m_credit = min_i(m_credit + sum, CMAX); m_last = m_cyc;
            end else if (m_cyc - m_last >= TMO) begin
                model_refund();
            end
        end else if (m_state == 2) begin
            m_err = (c != 3'd0);
            if (dn) begin
                m_cv = 1'b1; m_credit = 0; m_state = 0;
            end
        end else begin
            m_err = (c != 3'd0); m_state = 0;
        end
    endtask

    task automatic test_reset();
        cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({credit, price, change} !== 24'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 000000", {credit, price, change});
        end
        checks++;
        if ({change_valid, dispense, refund, err, busy, state} !== 7'd0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000000",
                               {change_valid, dispense, refund, err, busy, state});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_purchase();
        cyc(3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit !== 8'd5 || state !== 2'd1) begin
            errors++; $display("FAIL purchase_coin1: credit=%0d state=%0d expected 5/1", credit, state);
        end
        cyc(3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit !== 8'd6 || busy !== 1'b1) begin
            errors++; $display("FAIL purchase_coin0: credit=%0d busy=%b expected 6/1", credit, busy);
        end
        cyc(3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'd2 || dispense !== 1'b1 || price !== 8'd5 || err !== 1'b0) begin
            errors++; $display("FAIL purchase_confirm: state=%0d disp=%b price=%0d err=%b expected 2/1/5/0",
                               state, dispense, price, err);
        end
        cyc(3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (change_valid !== 1'b1 || change !== 8'd1 || dispense !== 1'b0 || credit !== 8'd0 || state !== 2'd0) begin
            errors++; $display("FAIL purchase_done: cv=%b change=%0d disp=%b credit=%0d state=%0d expected 1/1/0/0/0",
                               change_valid, change, dispense, credit, state);
        end
        cyc(3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (change_valid !== 1'b0 || price !== 8'd5 || busy !== 1'b0) begin
            errors++; $display("FAIL purchase_after: cv=%b price=%0d busy=%b expected 0/5/0", change_valid, price, busy);
        end
    endtask

    task automatic test_reject_cancel();
        cyc(3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b1 || state !== 2'd1 || credit !== 8'd5) begin
            errors++; $display("FAIL reject_price: err=%b state=%0d credit=%0d expected 1/1/5", err, state, credit);
        end
        cyc(3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b1 || state !== 2'd1 || credit !== 8'd5) begin
            errors++; $display("FAIL reject_invalid: err=%b state=%0d credit=%0d expected 1/1/5", err, state, credit);
        end
        cyc(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (state !== 2'd3 || refund !== 1'b1 || change_valid !== 1'b1 || change !== 8'd5 ||
            credit !== 8'd0 || err !== 1'b0) begin
            errors++; $display("FAIL cancel_refund: state=%0d ref=%b cv=%b change=%0d credit=%0d err=%b expected 3/1/1/5/0/0",
                               state, refund, change_valid, change, credit, err);
        end
        cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'd0 || refund !== 1'b0 || change_valid !== 1'b0) begin
            errors++; $display("FAIL cancel_idle: state=%0d ref=%b cv=%b expected 0/0/0", state, refund, change_valid);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 10; i++) cyc(3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit !== 8'd99) begin
            errors++; $display("FAIL saturate: credit=%0d expected 99", credit);
        end
        cyc(3'b111, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (change !== 8'd99 || err !== 1'b1 || refund !== 1'b1 || credit !== 8'd0) begin
            errors++; $display("FAIL saturate_cancel: change=%0d err=%b ref=%b credit=%0d expected 99/1/1/0",
                               change, err, refund, credit);
        end
        cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        cyc(3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (refund !== 1'b1 && n < 40) begin
            cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        checks++;
        if (n != TMO || change !== 8'd1 || credit !== 8'd0 || change_valid !== 1'b1) begin
            errors++; $display("FAIL timeout: cycles=%0d change=%0d credit=%0d cv=%b expected 16/1/0/1",
                               n, change, credit, change_valid);
        end
        cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_vend_reset();
        cyc(3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(3'b010, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b1 || credit !== 8'd6 || state !== 2'd2 || dispense !== 1'b1) begin
            errors++; $display("FAIL vend_coin: err=%b credit=%0d state=%0d disp=%b expected 1/6/2/1",
                               err, credit, state, dispense);
        end
        cyc(3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd0 || dispense !== 1'b0 || change_valid !== 1'b0 || credit !== 8'd0 || refund !== 1'b0) begin
            errors++; $display("FAIL vend_reset: state=%0d disp=%b cv=%b credit=%0d ref=%b expected 0/0/0/0/0",
                               state, dispense, change_valid, credit, refund);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  c, g;
        logic        cf, cn, dn, rs;
        logic [30:0] exp_v, got_v;
        int          dens;
        m_cyc = 0; m_last = 0;
        model_step(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            dens = ((i / 100) % 2 == 1) ? 4 : 45;
            c  = ($urandom_range(99) < dens) ? 3'($urandom) : 3'd0;
            g  = 3'($urandom);
            cf = ($urandom_range(99) < dens / 3);
            cn = ($urandom_range(99) < dens / 8);
            dn = ($urandom_range(99) < 15);
            rs = ($urandom_range(299) != 0);
            model_step(c, g, cf, cn, dn, rs);
            cyc(c, g, cf, cn, dn, rs);
            exp_v = {8'(m_credit), 8'(m_price), 8'(m_change), m_cv, (m_state == 2), m_refund,
                     m_err, (m_state != 0), 2'(m_state)};
            got_v = {credit, price, change, change_valid, dispense, refund, err, busy, state};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; coin = 3'd0; goods = 3'd0; confirm = 1'b0; cancel = 1'b0; done = 1'b0;
        test_reset();
        test_purchase();
        test_reject_cancel();
        test_saturate();
        test_timeout();
        test_vend_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
